mips_sequencer: RTL and testbench

Multicycle control FSM for the MIPS core. It steps each instruction through fetch, decode, execute, memory and writeback, and handshakes with the instruction and data memories. It produces the per-stage write enables and the PC source select that the datapath registers consume. It sits between the instruction decode outputs and the pc, register_file and data_memory enables, and replaces the single-cycle implicit sequencing.

---
 rtl/mips_sequencer_if.sv | 48 ++++
 rtl/mips_sequencer.sv | 160 ++++++++++++++++
 tb/tb_mips_sequencer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mips_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : mips_sequencer_if
// Description : Control/handshake bundle between the MIPS datapath and the
//               multicycle sequencer.
//               master : datapath side. Drives start/stop, the opcode, the
//                        ALU zero flag and the memory ready flags.
//               slave  : sequencer side. Drives the memory requests, the
//                        write enables, pc_src, state, halted, illegal and
//                        the retired-instruction count.
// Revision    : 1.0 - initial release
// ============================================================================
interface mips_sequencer_if #(
  parameter int CNT_W = 32
);
  // datapath -> sequencer
  logic             start;
  logic             stop;
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             imem_ready;
  logic             dmem_ready;
  // sequencer -> datapath
  logic             imem_req;
  logic             ir_we;
  logic             dmem_req;
  logic             dmem_we;
  logic             reg_we;
  logic             pc_we;
  logic [1:0]       pc_src;
  logic [2:0]       state;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output start, stop, opcode, alu_zero, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_src,
           state, halted, illegal, retired
  );

  modport slave (
    input  start, stop, opcode, alu_zero, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_src,
           state, halted, illegal, retired
  );
endinterface
`default_nettype wire

// File: rtl/mips_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mips_sequencer
// Description : Multicycle control FSM for the MIPS core. Steps each
//               instruction through FETCH, DECODE, EXEC, MEM and WB,
//               handshakes with the instruction and data memories, and
//               issues the per-stage write enables and the PC source select.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous active-high reset
//               bus  - mips_sequencer_if.slave: start/stop, opcode,
//                      alu_zero, imem/dmem ready in; imem_req, ir_we,
//                      dmem_req, dmem_we, reg_we, pc_we, pc_src, state,
//                      halted, illegal, retired out
// Revision    : 1.0 - initial release
// ============================================================================
module mips_sequencer #(
  parameter int WORD_SIZE = 32,
  parameter int CNT_W     = WORD_SIZE
) (
  input  logic            clk,
  input  logic            rst,
  mips_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [5:0] C_OP_RTYPE = 6'h00;
  localparam logic [5:0] C_OP_ADDI  = 6'h08;
  localparam logic [5:0] C_OP_LW    = 6'h23;
  localparam logic [5:0] C_OP_SW    = 6'h2B;
  localparam logic [5:0] C_OP_BEQ   = 6'h04;
  localparam logic [5:0] C_OP_J     = 6'h02;
  localparam logic [5:0] C_OP_HALT  = 6'h3F;

  state_t           state_q, state_d;
  logic             stop_pend_q;
  logic             halted_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retired_q;

  logic       w_imem_req, w_ir_we, w_dmem_req, w_dmem_we, w_reg_we, w_pc_we;
  logic [1:0] w_pc_src;
  logic       w_set_illegal;
  state_t     w_after_retire;

  // A retiring instruction returns to IDLE if a stop is pending or arriving.
  assign w_after_retire = (stop_pend_q || bus.stop) ? S_IDLE : S_FETCH;

  always_comb begin
    state_d       = state_q;
    w_imem_req    = 1'b0;
    w_ir_we       = 1'b0;
    w_dmem_req    = 1'b0;
    w_dmem_we     = 1'b0;
    w_reg_we      = 1'b0;
    w_pc_we       = 1'b0;
    w_pc_src      = 2'd0;
    w_set_illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) state_d = S_FETCH;
      end
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_ir_we = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          C_OP_J: begin
            w_pc_we  = 1'b1;
            w_pc_src = 2'd2;
            state_d  = w_after_retire;
          end
          C_OP_HALT: state_d = S_HALT;
          C_OP_RTYPE, C_OP_ADDI, C_OP_LW, C_OP_SW, C_OP_BEQ: state_d = S_EXEC;
          default: begin
            w_set_illegal = 1'b1;
            state_d       = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        if (bus.opcode == C_OP_BEQ) begin
          w_pc_we  = 1'b1;
          w_pc_src = bus.alu_zero ? 2'd1 : 2'd0;
          state_d  = w_after_retire;
        end else if (bus.opcode == C_OP_LW || bus.opcode == C_OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        w_dmem_req = 1'b1;
        w_dmem_we  = (bus.opcode == C_OP_SW);
        if (bus.dmem_ready) begin
          if (bus.opcode == C_OP_SW) begin
            w_pc_we = 1'b1;
            state_d = w_after_retire;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_pc_we  = 1'b1;
        state_d  = w_after_retire;
      end
      S_HALT: state_d = S_HALT;
      // Encoding 7 is unreachable; recover to IDLE.
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      stop_pend_q <= 1'b0;
      halted_q    <= 1'b0;
      illegal_q   <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q  <= state_d;
      halted_q <= (state_d == S_HALT);
      if (w_set_illegal) illegal_q <= 1'b1;
      // pc_we marks the single retire cycle of every completed instruction.
      if (w_pc_we) retired_q <= retired_q + CNT_W'(1);
      if (state_d == S_IDLE)
        stop_pend_q <= 1'b0;
      else if (bus.stop && state_q != S_IDLE && state_q != S_HALT)
        stop_pend_q <= 1'b1;
    end
  end

  assign bus.imem_req = w_imem_req;
  assign bus.ir_we    = w_ir_we;
  assign bus.dmem_req = w_dmem_req;
  assign bus.dmem_we  = w_dmem_we;
  assign bus.reg_we   = w_reg_we;
  assign bus.pc_we    = w_pc_we;
  assign bus.pc_src   = w_pc_src;
  assign bus.state    = state_q;
  assign bus.halted   = halted_q;
  assign bus.illegal  = illegal_q;
  assign bus.retired  = retired_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_sequencer
// Description : Directed self-checking bench for mips_sequencer (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_sequencer;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] OP_BAD  = 6'h15;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  mips_sequencer_if #(.CNT_W(4)) bus ();

  mips_sequencer #(.WORD_SIZE(32), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_src}
  wire [10:0] w_obs = {bus.state, bus.imem_req, bus.ir_we, bus.dmem_req,
                       bus.dmem_we, bus.reg_we, bus.pc_we, bus.pc_src};

  function automatic logic [10:0] ov(input logic [2:0] st, input logic ir,
                                     input logic iw, input logic dr,
                                     input logic dw, input logic rw,
                                     input logic pw, input logic [1:0] ps);
    return {st, ir, iw, dr, dw, rw, pw, ps};
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  // Check this cycle's outputs, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [10:0] want);
    #1;
    check(tag, 32'(w_obs), 32'(want));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.opcode = OP_R; bus.alu_zero = 1'b0;
    bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs",    32'(w_obs), 32'(ov(3'd0,0,0,0,0,0,0,2'd0)));
    check("rst_flags",   {30'd0, bus.halted, bus.illegal}, 32'd0);
    check("rst_retired", 32'(bus.retired), 32'd0);
    rst = 1'b0;

    // R-type: 1,2,3,5 with reg_we+pc_we only in WB
    bus.start = 1'b1; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
    cyc("r_idle",   ov(3'd0,0,0,0,0,0,0,2'd0));
    cyc("r_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("r_decode", ov(3'd2,0,0,0,0,0,0,2'd0));
    cyc("r_exec",   ov(3'd3,0,0,0,0,0,0,2'd0));
    cyc("r_wb",     ov(3'd5,0,0,0,0,1,1,2'd0));
    check("r_retired", 32'(bus.retired), 32'd1);

    // lw with three MEM wait cycles: 8 cycles total
    bus.opcode = OP_LW; bus.dmem_ready = 1'b0;
    cyc("lw_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("lw_decode", ov(3'd2,0,0,0,0,0,0,2'd0));
    cyc("lw_exec",   ov(3'd3,0,0,0,0,0,0,2'd0));
    cyc("lw_mem0",   ov(3'd4,0,0,1,0,0,0,2'd0));
    cyc("lw_mem1",   ov(3'd4,0,0,1,0,0,0,2'd0));
    cyc("lw_mem2",   ov(3'd4,0,0,1,0,0,0,2'd0));
    bus.dmem_ready = 1'b1;
    cyc("lw_mem3",   ov(3'd4,0,0,1,0,0,0,2'd0));
    cyc("lw_wb",     ov(3'd5,0,0,0,0,1,1,2'd0));
    check("lw_retired", 32'(bus.retired), 32'd2);

    // beq taken, then not taken
    bus.opcode = OP_BEQ; bus.alu_zero = 1'b1;
    cyc("beq1_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("beq1_decode", ov(3'd2,0,0,0,0,0,0,2'd0));
    cyc("beq1_exec",   ov(3'd3,0,0,0,0,0,1,2'd1));
    bus.alu_zero = 1'b0;
    cyc("beq0_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("beq0_decode", ov(3'd2,0,0,0,0,0,0,2'd0));
    cyc("beq0_exec",   ov(3'd3,0,0,0,0,0,1,2'd0));
    check("beq_retired", 32'(bus.retired), 32'd4);

    // j: 2 cycles, pc_src=2 in DECODE
    bus.opcode = OP_J;
    cyc("j_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("j_decode", ov(3'd2,0,0,0,0,0,1,2'd2));

    // sw with stop pulsed in MEM; returns to IDLE, no further fetch
    bus.opcode = OP_SW; bus.dmem_ready = 1'b0; bus.start = 1'b0;
    cyc("sw_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("sw_decode", ov(3'd2,0,0,0,0,0,0,2'd0));
    cyc("sw_exec",   ov(3'd3,0,0,0,0,0,0,2'd0));
    bus.stop = 1'b1;
    cyc("sw_mem0",   ov(3'd4,0,0,1,1,0,0,2'd0));
    bus.stop = 1'b0; bus.dmem_ready = 1'b1;
    cyc("sw_mem1",   ov(3'd4,0,0,1,1,0,1,2'd0));
    cyc("sw_idle0",  ov(3'd0,0,0,0,0,0,0,2'd0));
    cyc("sw_idle1",  ov(3'd0,0,0,0,0,0,0,2'd0));
    check("sw_retired", 32'(bus.retired), 32'd6);

    // start+stop together in IDLE: exactly one instruction via stop_pend
    bus.start = 1'b1; bus.stop = 1'b1; bus.opcode = OP_J;
    cyc("ss_idle",   ov(3'd0,0,0,0,0,0,0,2'd0));
    cyc("ss_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    bus.start = 1'b0; bus.stop = 1'b0;
    cyc("ss_decode", ov(3'd2,0,0,0,0,0,1,2'd2));
    cyc("ss_idle1",  ov(3'd0,0,0,0,0,0,0,2'd0));
    check("ss_retired", 32'(bus.retired), 32'd7);

    // counter wrap: 8 more retires reach 15, the next wraps to 0
    bus.start = 1'b1;
    cyc("wr_idle", ov(3'd0,0,0,0,0,0,0,2'd0));
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      @(posedge clk); #1;
    end
    check("wr_15", 32'(bus.retired), 32'd15);
    cyc("wr_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("wr_decode", ov(3'd2,0,0,0,0,0,1,2'd2));
    check("wr_0", 32'(bus.retired), 32'd0);

    // illegal opcode: halt from cycle 3, no retire, start ignored
    bus.opcode = OP_BAD;
    cyc("il_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("il_decode", ov(3'd2,0,0,0,0,0,0,2'd0));
    check("il_flags", {30'd0, bus.halted, bus.illegal}, 32'd3);
    cyc("il_halt0",  ov(3'd6,0,0,0,0,0,0,2'd0));
    cyc("il_halt1",  ov(3'd6,0,0,0,0,0,0,2'd0));
    check("il_flags2",   {30'd0, bus.halted, bus.illegal}, 32'd3);
    check("il_retired",  32'(bus.retired), 32'd0);

    // rst clears flags immediately
    rst = 1'b1;
    #1;
    check("il_rst", {27'd0, bus.state, bus.halted, bus.illegal}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // halt opcode: halted without illegal
    bus.opcode = OP_HALT;
    cyc("h_idle",   ov(3'd0,0,0,0,0,0,0,2'd0));
    cyc("h_fetch",  ov(3'd1,1,1,0,0,0,0,2'd0));
    cyc("h_decode", ov(3'd2,0,0,0,0,0,0,2'd0));
    cyc("h_halt",   ov(3'd6,0,0,0,0,0,0,2'd0));
    check("h_flags", {30'd0, bus.halted, bus.illegal}, 32'd2);

    // rst during FETCH drops imem_req at once
    rst = 1'b1;
    #1;
    rst = 1'b0;
    bus.imem_ready = 1'b0;
    cyc("f_idle",  ov(3'd0,0,0,0,0,0,0,2'd0));
    cyc("f_fetch", ov(3'd1,1,0,0,0,0,0,2'd0));
    rst = 1'b1;
    #1;
    check("f_rst", 32'(w_obs), 32'(ov(3'd0,0,0,0,0,0,0,2'd0)));
    @(posedge clk); #1;
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
